// File: rtl/mem_port_arbiter.sv
// Arbiter that shares one single-port memory between instruction fetch (IF)
// and the data stage (D). D has fixed priority. A starvation counter forces
// an IF grant after STARVE_MAX consecutive D grants made while IF waits.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_ack_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ack_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state_q, state_d;
  logic              owner_d_q, owner_d_d;   // 1 = D owns the access
  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              pick_d;

  // Next-state logic: grant in IDLE, wait for memory in BUSY, ack in DONE.
  always_comb begin
    state_d      = state_q;
    owner_d_d    = owner_d_q;
    starve_cnt_d = starve_cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_data_d    = if_data_q;
    d_rdata_d    = d_rdata_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    pick_d       = d_req_i && !(if_req_i && (starve_cnt_q == STARVE_LIM));
    unique case (state_q)
      IDLE: begin
        if (if_req_i || d_req_i) begin
          owner_d_d = pick_d;
          mem_req_d = 1'b1;
          state_d   = BUSY;
          if (pick_d) begin
            mem_we_d    = d_we_i;
            mem_addr_d  = d_addr_i;
            mem_wdata_d = d_wdata_i;
            if (if_req_i && (starve_cnt_q < STARVE_LIM)) begin
              starve_cnt_d = starve_cnt_q + 4'd1;
            end
          end else begin
            mem_we_d     = 1'b0;
            mem_addr_d   = if_addr_i;
            mem_wdata_d  = '0;
            starve_cnt_d = '0;
          end
        end
      end
      BUSY: begin
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          if (owner_d_q) begin
            d_ack_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata_i;
            end
          end else begin
            if_ack_d  = 1'b1;
            if_data_d = mem_rdata_i;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any access in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      owner_d_q    <= 1'b0;
      starve_cnt_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_data_q    <= '0;
      d_rdata_q    <= '0;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_d_q    <= owner_d_d;
      starve_cnt_q <= starve_cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_data_q    <= if_data_d;
      d_rdata_q    <= d_rdata_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_data_o   = if_data_q;
  assign d_rdata_o   = d_rdata_q;
  assign if_ack_o    = if_ack_q;
  assign d_ack_o     = d_ack_q;
  assign stall_o     = (if_req_i & ~if_ack_q) | (d_req_i & ~d_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level model with a behavioural memory.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned SMAX = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          if_req_i, d_req_i, d_we_i, mem_ack_i;
  logic [AW-1:0] if_addr_i, d_addr_i;
  logic [DW-1:0] d_wdata_i, mem_rdata_i;
  logic [DW-1:0] if_data_o, d_rdata_o, mem_wdata_o;
  logic [AW-1:0] mem_addr_o;
  logic          if_ack_o, d_ack_o, stall_o, mem_req_o, mem_we_o;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_data_o(if_data_o), .if_ack_o(if_ack_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_rdata_o(d_rdata_o), .d_ack_o(d_ack_o), .stall_o(stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  // Transaction-level model: at most one access in flight, described by
  // the cycle numbers at which its phases must be visible.
  bit          m_busy;
  bit          m_own_d;
  bit          m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  int unsigned g_cyc, mack_cyc, ack_cyc, free_cyc;
  int unsigned m_starve;
  int unsigned next_lat;
  logic [31:0] exp_if_data, exp_d_rdata;
  logic [31:0] mem_m [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_busy      = 0;
    m_starve    = 0;
    exp_if_data = '0;
    exp_d_rdata = '0;
    free_cyc    = cyc;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_data"}, if_data_o, 32'h0);
    chk({tag, "_if_ack"}, 32'(if_ack_o), 32'h0);
    chk({tag, "_d_rdata"}, d_rdata_o, 32'h0);
    chk({tag, "_d_ack"}, 32'(d_ack_o), 32'h0);
    chk({tag, "_stall"}, 32'(stall_o), 32'h0);
    chk({tag, "_mem_req"}, 32'(mem_req_o), 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we_o), 32'h0);
    chk({tag, "_mem_addr"}, mem_addr_o, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
  endtask

  // One clock: predict the grant at the coming edge, play the memory,
  // then compare every output against the model.
  task automatic step(input bit spur);
    bit exp_ia, exp_da, win;
    if (!m_busy && cyc >= free_cyc && (if_req_i || d_req_i)) begin
      m_own_d = d_req_i && !(if_req_i && m_starve == SMAX);
      if (m_own_d) begin
        m_addr = d_addr_i; m_we = d_we_i; m_wdata = d_wdata_i;
        if (if_req_i && m_starve < SMAX) m_starve++;
      end else begin
        m_addr = if_addr_i; m_we = 0; m_wdata = '0;
        m_starve = 0;
      end
      m_busy   = 1;
      g_cyc    = cyc + 1;
      mack_cyc = g_cyc + next_lat;
      ack_cyc  = mack_cyc + 1;
      free_cyc = ack_cyc + 1;
    end
    @(posedge clk_i);
    #1;
    cyc++;
    mem_ack_i   = 1'b0;
    mem_rdata_i = $urandom;
    win = m_busy && cyc >= g_cyc && cyc <= mack_cyc;
    if (m_busy && cyc == mack_cyc) begin
      mem_ack_i = 1'b1;
      if (m_we) mem_m[m_addr] = m_wdata;
      else mem_rdata_i = mem_rd(m_addr);
      m_rdata = mem_rdata_i;
    end else if (spur && !win) begin
      mem_ack_i = 1'b1;
    end
    exp_ia = 0;
    exp_da = 0;
    if (m_busy && cyc == ack_cyc) begin
      if (m_own_d) begin
        exp_da = 1;
        if (!m_we) exp_d_rdata = m_rdata;
      end else begin
        exp_ia = 1;
        exp_if_data = m_rdata;
      end
      m_busy = 0;
    end
    chk("mem_req", 32'(mem_req_o), 32'(win));
    if (win) begin
      chk("mem_addr", mem_addr_o, m_addr);
      chk("mem_we", 32'(mem_we_o), 32'(m_we));
      chk("mem_wdata", mem_wdata_o, m_wdata);
    end
    chk("if_ack", 32'(if_ack_o), 32'(exp_ia));
    chk("d_ack", 32'(d_ack_o), 32'(exp_da));
    chk("if_data", if_data_o, exp_if_data);
    chk("d_rdata", d_rdata_o, exp_d_rdata);
    chk("stall", 32'(stall_o), 32'((if_req_i & ~exp_ia) | (d_req_i & ~exp_da)));
  endtask

  task automatic run_until_ack(input bit want_d, input bit spur, output int unsigned at);
    at = 0;
    for (int i = 0; i < 40; i++) begin
      step(spur);
      if (want_d ? d_ack_o : if_ack_o) begin
        at = cyc;
        return;
      end
    end
    chk("ack_timeout", 32'(want_d ? d_ack_o : if_ack_o), 32'h1);
  endtask

  initial begin
    int unsigned c0, at, at2, nd, nd_before;
    bit if_done, d_after, in_if, in_d;

    rst_i = 1'b0;
    if_req_i = 0; d_req_i = 0; d_we_i = 0; mem_ack_i = 0;
    if_addr_i = '0; d_addr_i = '0; d_wdata_i = '0; mem_rdata_i = '0;
    next_lat = 0;
    #1;
    chk_all_zero("por");
    @(posedge clk_i); @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    model_reset();

    // Idle with no requests, plus spurious memory acks while idle.
    for (int i = 0; i < 3; i++) step(1'b1);

    // Single fetch, memory acks in the first busy cycle.
    mem_m[32'h10] = 32'h8C22_0004;
    next_lat = 0;
    if_addr_i = 32'h10; if_req_i = 1;
    c0 = cyc;
    run_until_ack(1'b0, 1'b0, at);
    chk("fetch_latency", at - c0, 32'd2);
    chk("fetch_data", if_data_o, 32'h8C22_0004);
    if_req_i = 0;
    step(1'b0);

    // Data write with the memory ack delayed five cycles.
    next_lat = 5;
    d_addr_i = 32'h20; d_we_i = 1; d_wdata_i = 32'hDEAD_BEEF; d_req_i = 1;
    c0 = cyc;
    run_until_ack(1'b1, 1'b0, at);
    chk("write_latency", at - c0, 32'd7);
    chk("write_rdata_unchanged", d_rdata_o, 32'h0);
    d_req_i = 0; d_we_i = 0;
    step(1'b1);

    // Simultaneous requests: D first, IF right after D completes.
    next_lat = 1;
    d_addr_i = 32'h20; d_we_i = 0; d_req_i = 1;
    if_addr_i = 32'h10; if_req_i = 1;
    run_until_ack(1'b1, 1'b0, at);
    chk("simul_d_data", d_rdata_o, 32'hDEAD_BEEF);
    d_req_i = 0;
    run_until_ack(1'b0, 1'b0, at2);
    chk("simul_if_after_d", at2 - at, 32'd4);
    chk("simul_if_data", if_data_o, 32'h8C22_0004);
    if_req_i = 0;
    step(1'b0);

    // Starvation: D back to back while IF is held.
    next_lat = 0;
    if_addr_i = 32'h14; if_req_i = 1;
    d_addr_i = 32'h0; d_we_i = 0; d_req_i = 1;
    nd = 0; nd_before = 0; if_done = 0; d_after = 0;
    for (int i = 0; i < 80 && !d_after; i++) begin
      step(1'b0);
      if (if_ack_o) begin
        if_done = 1; nd_before = nd; if_req_i = 0;
      end
      if (d_ack_o) begin
        if (if_done) d_after = 1;
        else nd++;
        d_addr_i = d_addr_i + 32'd4;
      end
    end
    chk("starve_d_grants", nd_before, 32'(SMAX));
    chk("starve_if_served", 32'(if_done), 32'h1);
    chk("starve_d_resumes", 32'(d_after), 32'h1);
    d_req_i = 0;
    step(1'b0);

    // D request dropped while its access is in progress.
    next_lat = 3;
    d_addr_i = 32'h24; d_we_i = 0; d_req_i = 1;
    step(1'b0);
    d_req_i = 0;
    run_until_ack(1'b1, 1'b1, at);
    chk("drop_still_acked", 32'(d_ack_o), 32'h1);
    step(1'b1);

    // Reset in the middle of a long access.
    next_lat = 10;
    if_addr_i = 32'h18; if_req_i = 1;
    for (int i = 0; i < 3; i++) step(1'b0);
    chk("pre_reset_mem_req", 32'(mem_req_o), 32'h1);
    #2;
    rst_i = 0; if_req_i = 0;
    #1;
    chk_all_zero("mid_reset");
    @(posedge clk_i);
    #1;
    cyc++;
    mem_ack_i = 0;
    rst_i = 1;
    model_reset();
    for (int i = 0; i < 14; i++) step(1'b0);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      next_lat = $urandom_range(0, 4);
      step($urandom_range(0, 7) == 0);
      if (if_ack_o) if_req_i = 0;
      if (d_ack_o) d_req_i = 0;
      in_if = m_busy && !m_own_d;
      in_d  = m_busy && m_own_d;
      if (!if_req_i && !in_if && $urandom_range(0, 2) == 0) begin
        if_req_i = 1; if_addr_i = $urandom_range(0, 7) << 2;
      end
      if (!d_req_i && !in_d && $urandom_range(0, 2) == 0) begin
        d_req_i = 1; d_we_i = 1'($urandom_range(0, 1));
        d_addr_i = $urandom_range(0, 7) << 2; d_wdata_i = $urandom;
      end
      if (in_if && if_req_i && $urandom_range(0, 9) == 0) if_req_i = 0;
      if (in_d && d_req_i && $urandom_range(0, 9) == 0) d_req_i = 0;
    end
    if_req_i = 0; d_req_i = 0;
    for (int i = 0; i < 12; i++) step(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
